// File: rtl/tail_light_monitor.sv
// tail_light_monitor: measures per-line PWM duty over 256-cycle frames,
// quantizes each line to a brightness level and checks the blink sequence.

// One lamp line: saturating high-sample counter plus level quantizer.
module tlm_lane #(
  parameter int FRAME_BITS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       light,
  input  logic       frame_end,
  output logic [2:0] lvl
);
  localparam int CW = FRAME_BITS + 1;
  localparam logic [CW-1:0] FULL = CW'(1) << FRAME_BITS;

  logic [CW-1:0] hc, sum, n;

  // Count including the current sample, clamped at a full frame.
  always_comb begin
    sum = hc + {{(CW-1){1'b0}}, light};
    n   = (sum > FULL) ? FULL : sum;
  end

  // Accumulate; the closing edge's sample is in n, then start the next frame at 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          hc <= '0;
    else if (frame_end) hc <= '0;
    else                hc <= n;
  end

  // Log-spaced brightness buckets of the final count.
  always_comb begin
    lvl = 3'd4;
    if (n == '0)              lvl = 3'd0;
    else if (n < CW'(8))      lvl = 3'd1;
    else if (n < CW'(32))     lvl = 3'd2;
    else if (n < CW'(128))    lvl = 3'd3;
  end
endmodule

module tail_light_monitor #(
  parameter int FRAME_BITS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  light,
  output logic [17:0] level,
  output logic        frame_valid,
  output logic [1:0]  direction,
  output logic [3:0]  step,
  output logic        seq_error,
  output logic        step_jump
);
  localparam int NUM_LANES = 6;

  logic [FRAME_BITS-1:0]       fc;
  logic                        frame_end;
  logic [NUM_LANES-1:0][2:0]   lvl_n;
  logic [3:0]                  prev_step;

  assign frame_end = (fc == '1);

  // Free-running frame position.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) fc <= '0;
    else       fc <= fc + 1'b1;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      tlm_lane #(.FRAME_BITS(FRAME_BITS)) u_lane (
        .clk       (clk),
        .reset     (reset),
        .light     (light[gi]),
        .frame_end (frame_end),
        .lvl       (lvl_n[gi])
      );
    end
  endgenerate

  logic       side_r, side_l, valid, err_n, jump_n;
  logic [2:0] a1, a2, a3;
  logic [3:0] step_n;

  // Sequence decode on the active side: leading full lamps, one partial, rest dark.
  always_comb begin
    side_r = (lvl_n[0] != 3'd0) || (lvl_n[1] != 3'd0) || (lvl_n[2] != 3'd0);
    side_l = (lvl_n[5] != 3'd0) || (lvl_n[4] != 3'd0) || (lvl_n[3] != 3'd0);
    a1 = side_r ? lvl_n[0] : lvl_n[5];
    a2 = side_r ? lvl_n[1] : lvl_n[4];
    a3 = side_r ? lvl_n[2] : lvl_n[3];
    if (a1 == 3'd4) valid = (a2 == 3'd4) || (a3 == 3'd0);
    else            valid = (a2 == 3'd0) && (a3 == 3'd0);
    step_n = {1'b0, a1} + {1'b0, a2} + {1'b0, a3};
    err_n  = (side_r && side_l) || !valid;
    jump_n = !err_n && (step_n != prev_step) && (step_n != prev_step + 4'd1)
             && (step_n != 4'd0);
  end

  // Frame results: latched on the closing edge, held for the whole next frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level       <= '0;
      direction   <= '0;
      prev_step   <= '0;
      seq_error   <= 1'b0;
      step_jump   <= 1'b0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= frame_end;
      if (frame_end) begin
        level     <= lvl_n;
        direction <= {side_l, side_r};
        seq_error <= err_n;
        step_jump <= jump_n;
        if (!err_n) prev_step <= step_n;
      end
    end
  end

  assign step = prev_step;
endmodule

// File: tb/tb_tail_light_monitor.sv
// Directed bench for tail_light_monitor: PWM frames with hand-computed results.
module tb_tail_light_monitor;
  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  light;
  logic [17:0] level;
  logic        frame_valid;
  logic [1:0]  direction;
  logic [3:0]  step;
  logic        seq_error;
  logic        step_jump;

  int checks = 0;
  int failures = 0;

  tail_light_monitor #(.FRAME_BITS(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .light       (light),
    .level       (level),
    .frame_valid (frame_valid),
    .direction   (direction),
    .step        (step),
    .seq_error   (seq_error),
    .step_jump   (step_jump)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [17:0] got, input logic [17:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk(input string tag, input logic [17:0] el, input logic [1:0] ed,
                     input logic [3:0] es, input logic ee, input logic ej,
                     input logic efv);
    cmp({tag, ".level"}, level, el);
    cmp({tag, ".dir"},   18'(direction), 18'(ed));
    cmp({tag, ".step"},  18'(step), 18'(es));
    cmp({tag, ".err"},   18'(seq_error), 18'(ee));
    cmp({tag, ".jump"},  18'(step_jump), 18'(ej));
    cmp({tag, ".fv"},    18'(frame_valid), 18'(efv));
  endtask

  // One full frame of PWM (high while (k+ph)%256 < duty); duty 256 = always high.
  task automatic frame(input int d0, input int d1, input int d2, input int d3,
                       input int d4, input int d5, input int ph);
    int p;
    for (int k = 0; k < 256; k++) begin
      p = (k + ph) % 256;
      light = {p < d5, p < d4, p < d3, p < d2, p < d1, p < d0};
      @(posedge clk); #1;
      if (k == 127) cmp("fv_mid", 18'(frame_valid), 18'd0);
      if (k == 254) cmp("fv_pre", 18'(frame_valid), 18'd0);
    end
  endtask

  initial begin
    logic [17:0] el;
    int dd[4];
    int du[3];
    int jj, rr;
    dd = '{3, 15, 63, 255};
    light = '0;
    reset = 1'b1;
    #1;
    chk("reset0", 18'd0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Idle frames
    for (int f = 0; f < 3; f++) begin
      frame(0, 0, 0, 0, 0, 0, 0);
      chk("idle", 18'd0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    end
    @(posedge clk); #1;
    cmp("fv_pulse_end", 18'(frame_valid), 18'd0);
    // Realign: one edge of the next frame already consumed with light=0
    for (int k = 1; k < 256; k++) begin
      @(posedge clk); #1;
    end
    chk("idle4", 18'd0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1);

    // Right side, step 6 (jump from 0)
    frame(255, 15, 0, 0, 0, 0, 37);
    chk("right6", {3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd4}, 2'd1, 4'd6, 1'b0, 1'b1, 1'b1);
    frame(0, 0, 0, 0, 0, 0, 0);
    chk("idle5", 18'd0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1);

    // Left sweep 1..12 on light[5] -> light[3]
    for (int s = 1; s <= 12; s++) begin
      jj = (s - 1) / 4;
      rr = (s - 1) % 4;
      el = '0;
      for (int j = 0; j < 3; j++) begin
        du[j] = (j < jj) ? 255 : (j == jj) ? dd[rr] : 0;
        if (j < jj)       el[3*(5-j) +: 3] = 3'd4;
        else if (j == jj) el[3*(5-j) +: 3] = 3'(rr + 1);
      end
      frame(0, 0, 0, du[2], du[1], du[0], s * 17);
      chk($sformatf("sweep%0d", s), el, 2'd2, 4'(s), 1'b0, 1'b0, 1'b1);
    end
    frame(0, 0, 0, 0, 0, 0, 0);
    chk("sweep_end", 18'd0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1);

    // Invalid patterns
    frame(255, 0, 0, 0, 0, 0, 90);
    chk("r4", {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd4}, 2'd1, 4'd4, 1'b0, 1'b1, 1'b1);
    frame(0, 255, 0, 0, 0, 0, 5);
    chk("gap", {3'd0, 3'd0, 3'd0, 3'd0, 3'd4, 3'd0}, 2'd1, 4'd4, 1'b1, 1'b0, 1'b1);
    frame(255, 0, 0, 0, 0, 255, 200);
    chk("both", {3'd4, 3'd0, 3'd0, 3'd0, 3'd0, 3'd4}, 2'd3, 4'd4, 1'b1, 1'b0, 1'b1);

    // Jump 4 -> 7, then back to 0
    frame(255, 0, 0, 0, 0, 0, 0);
    chk("s4", {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd4}, 2'd1, 4'd4, 1'b0, 1'b0, 1'b1);
    frame(255, 63, 0, 0, 0, 0, 128);
    chk("s7", {3'd0, 3'd0, 3'd0, 3'd0, 3'd3, 3'd4}, 2'd1, 4'd7, 1'b0, 1'b1, 1'b1);
    frame(0, 0, 0, 0, 0, 0, 0);
    chk("s0", 18'd0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1);

    // Quantizer boundaries and saturation
    frame(256, 128, 127, 0, 0, 0, 3);
    chk("bnd_r", {3'd0, 3'd0, 3'd0, 3'd3, 3'd4, 3'd4}, 2'd1, 4'd11, 1'b0, 1'b1, 1'b1);
    frame(0, 0, 0, 8, 7, 32, 77);
    chk("bnd_l", {3'd3, 3'd1, 3'd2, 3'd0, 3'd0, 3'd0}, 2'd2, 4'd11, 1'b1, 1'b0, 1'b1);
    frame(1, 0, 0, 0, 0, 31, 250);
    chk("bnd_b", {3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1}, 2'd3, 4'd11, 1'b1, 1'b0, 1'b1);

    // Mid-frame reset at fc=100 with every line high beforehand
    light = 6'h3f;
    repeat (100) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rst_mid", 18'd0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    frame(3, 0, 0, 0, 0, 0, 11);
    chk("post_rst", {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1}, 2'd1, 4'd1, 1'b0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
